// File: rtl/ffra_pkg.sv
// Shared widths, controller state encoding and channel-index sizing for ffra_sched.
package ffra_pkg;

  localparam int A_W   = 8;
  localparam int CI_W  = 16;
  localparam int O_W   = 16;
  localparam int CNT_W = 3;   // holds datapath latency 0..7

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Width of a channel index; kept at least 1 bit so a degenerate N never yields a zero-width vector.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ffra_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at N.
module ffra_rr_arb
  import ffra_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = ch_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the farthest slot back toward ptr so the nearest requester overwrites earlier hits.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ffra_sched.sv
// Round-robin controller sharing one multiply-add datapath among N burst requesters.
// Each burst chains a*b+ci with the previous result as ci; one result is returned per burst.
module ffra_sched
  import ffra_pkg::*;
#(
  parameter int N      = 4,
  parameter int DP_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N*A_W-1:0]      req_a,
  input  logic [N*A_W-1:0]      req_b,
  input  logic [N*CI_W-1:0]     req_ci,
  input  logic [N-1:0]          req_last,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [$clog2(N)-1:0]  rsp_id,
  output logic [O_W-1:0]        rsp_data,
  output logic [A_W-1:0]        dp_a,
  output logic [A_W-1:0]        dp_b,
  output logic [CI_W-1:0]       dp_ci,
  input  logic [O_W-1:0]        dp_o,
  output logic                  busy
);

  localparam int IW = ch_w(N);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [A_W-1:0]   a_q, a_d, b_q, b_d;
  logic [CI_W-1:0]  ci_q, ci_d;
  logic             last_q, last_d;
  logic [O_W-1:0]   acc_q, acc_d;
  logic [N-1:0]     ready_c;

  logic [N-1:0]     arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  ffra_rr_arb #(.N(N), .IW(IW)) u_arb (
    .req (req_valid),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Datapath operands come straight from the beat registers so they stay stable through WAIT.
  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign dp_ci     = ci_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = acc_q;
  assign rsp_id    = grant_q;
  assign busy      = (state_q != IDLE);
  // Ready is combinational from req_valid in IDLE; mask it so reset really silences every output.
  assign req_ready = ready_c & {N{rst_n}};

  // Next-state, beat capture, accumulator chaining and ready generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    a_d     = a_q;
    b_d     = b_q;
    ci_d    = ci_q;
    last_d  = last_q;
    acc_d   = acc_q;
    ready_c = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          ready_c = arb_gnt;
          grant_d = arb_idx;
          a_d     = req_a[int'(arb_idx)*A_W +: A_W];
          b_d     = req_b[int'(arb_idx)*A_W +: A_W];
          ci_d    = req_ci[int'(arb_idx)*CI_W +: CI_W];
          last_d  = req_last[arb_idx];
          cnt_d   = CNT_W'(DP_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          acc_d   = dp_o;
          state_d = last_q ? RESP : BEAT;
        end
      end
      BEAT: begin
        // Burst is locked to its owner; later beats chain on the running result.
        ready_c[grant_q] = 1'b1;
        if (req_valid[grant_q]) begin
          a_d     = req_a[int'(grant_q)*A_W +: A_W];
          b_d     = req_b[int'(grant_q)*A_W +: A_W];
          ci_d    = acc_q;
          last_d  = req_last[grant_q];
          cnt_d   = CNT_W'(DP_LAT);
          state_d = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rr_d    = (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ci_q    <= ci_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_ffra_sched.sv
// Directed bench for ffra_sched with a one-cycle multiply-add datapath model.
module tb_ffra_sched;
  localparam int N = 4;
  localparam int DP_LAT = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*8-1:0]  req_a = '0;
  logic [N*8-1:0]  req_b = '0;
  logic [N*16-1:0] req_ci = '0;
  logic [N-1:0]    req_last = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_data;
  logic [7:0]      dp_a, dp_b;
  logic [15:0]     dp_ci;
  logic [15:0]     dp_o = '0;
  logic            busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Datapath stand-in: registered a*b+ci, wrapping at 16 bits (latency 1).
  always @(posedge clk) dp_o <= 16'(dp_a) * 16'(dp_b) + dp_ci;

  ffra_sched #(.N(N), .DP_LAT(DP_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci), .req_last(req_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .dp_a(dp_a), .dp_b(dp_b), .dp_ci(dp_ci), .dp_o(dp_o), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] ci, input logic last);
    req_valid[ch] = 1'b1;
    req_a[ch*8 +: 8] = a;
    req_b[ch*8 +: 8] = b;
    req_ci[ch*16 +: 16] = ci;
    req_last[ch] = last;
  endtask

  // Present a beat from a negedge, wait for its ready, let the edge accept it, return at the next negedge.
  task automatic send_beat(input int ch, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] ci, input logic last);
    bit ok = 0;
    set_ch(ch, a, b, ci, last);
    for (int k = 0; k < 100; k++) begin
      #1;
      if (req_ready[ch]) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("rdy_timeout", 32'(ok), 1);
    if (ok) chk("rdy_onehot", 32'(req_ready), 32'(1) << ch);
    @(posedge clk);
    @(negedge clk);
    req_valid[ch] = 1'b0;
    req_last[ch] = 1'b0;
  endtask

  task automatic wait_rsp(input int id, input logic [15:0] data);
    bit ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (rsp_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("rsp_timeout", 32'(ok), 1);
    if (ok) begin
      chk("rsp_id", 32'(rsp_id), 32'(id));
      chk("rsp_data", 32'(rsp_data), 32'(data));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, 32'(req_ready), 0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 0);
    chk({tag, "_rspid"}, 32'(rsp_id), 0);
    chk({tag, "_rspd"}, 32'(rsp_data), 0);
    chk({tag, "_dp"}, {dp_a, dp_b, dp_ci}, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  int exp_id[5] = '{0, 1, 2, 3, 0};
  int got_n;
  bit ok;

  initial begin
    // Reset state
    #2 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat ch0: 3*4+5 = 17; result appears DP_LAT+1 edges after the accept edge
    send_beat(0, 8'd3, 8'd4, 16'd5, 1'b1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_dpa", 32'(dp_a), 3);
    chk("t1_early0", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("t1_early1", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("t1_lat", 32'(rsp_valid), 1);
    chk("t1_rdy_resp", 32'(req_ready), 0);
    wait_rsp(0, 16'd17);
    chk("t1_idle", 32'(busy), 0);

    // ch2 burst: 1+2*3=7, 7+4*5=27, 27+6*7=69; ch0 valid during BEAT must not be granted
    send_beat(2, 8'd2, 8'd3, 16'd1, 1'b0);
    set_ch(0, 8'd1, 8'd1, 16'd0, 1'b1);
    send_beat(2, 8'd4, 8'd5, 16'hFFFF, 1'b0);
    req_valid[0] = 1'b0;
    send_beat(2, 8'd6, 8'd7, 16'hFFFF, 1'b1);
    wait_rsp(2, 16'd69);

    // Wrap: 255*255 + 0xFFFF mod 2^16 = 0xFE00 (rr pointer now at 3)
    send_beat(3, 8'd255, 8'd255, 16'hFFFF, 1'b1);
    wait_rsp(3, 16'hFE00);

    // Backpressure on ch0 (10*10+1 = 101) while ch1 is waiting
    send_beat(0, 8'd10, 8'd10, 16'd1, 1'b1);
    set_ch(1, 8'd1, 8'd1, 16'd0, 1'b1);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("bp_timeout", 32'(ok), 1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data", 32'(rsp_data), 101);
      chk("bp_id", 32'(rsp_id), 0);
      chk("bp_rdy", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_done", 32'(busy), 0);

    // Round robin from reset with all four channels valid: ch i -> (i+1)*2+i
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_ch(i, 8'(i + 1), 8'd2, 16'(i), 1'b1);
    #1 chk("rr_rst_rdy", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    got_n = 0;
    for (int k = 0; k < 200 && got_n < 5; k++) begin
      @(negedge clk);
      #1;
      chk("rr_onehot", 32'($countones(req_ready) <= 1), 1);
      if (rsp_valid) begin
        chk("rr_id", 32'(rsp_id), 32'(exp_id[got_n]));
        chk("rr_data", 32'(rsp_data), 32'((exp_id[got_n] + 1) * 2 + exp_id[got_n]));
        got_n++;
      end
    end
    chk("rr_count", 32'(got_n), 5);
    req_valid = '0;
    req_last = '0;
    @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);

    // Reset during WAIT of a ch1 burst: outputs clear at once, burst lost, pointer back to 0
    send_beat(1, 8'd3, 8'd3, 16'd0, 1'b0);
    set_ch(1, 8'd5, 8'd5, 16'd0, 1'b0);
    rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid || busy) ok = 1;
    end
    chk("midrst_quiet", 32'(ok), 0);
    set_ch(0, 8'd1, 8'd1, 16'd0, 1'b1);
    set_ch(1, 8'd2, 8'd2, 16'd0, 1'b1);
    #1 chk("midrst_ptr", 32'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(0, 16'd1);
    req_valid = '0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
